rx_store_buf_dispatch: RTL

// - Shares one RX store-buffer queue among NUM_CP rx_payload_store_buf_cp copier instances.

---
 rtl/tcp_pkg.sv | 18 +
 rtl/rx_store_buf_rr_pick.sv | 31 +++
 rtl/rx_store_buf_dispatch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/tcp_pkg.sv
// Shared TCP receive-path types: RX store-buffer queue entry and copier-array sizing.
package tcp_pkg;

    localparam int FLOWID_W            = 16;
    localparam int RX_STORE_BUF_NUM_CP = 2;

    typedef struct packed {
        logic [FLOWID_W-1:0] flowid;
        logic [31:0]         buf_addr;
        logic [15:0]         len;
    } rx_store_buf_q_struct;

    // Index width that stays at least one bit even for a single copier.
    function automatic int cp_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rx_store_buf_rr_pick.sv
// Round-robin picker: first eligible copier scanning upward from rr_ptr, modulo NUM_CP.
// Latency: combinational, zero cycles.
// Backpressure: none; any_grant low when no copier is eligible.
module rx_store_buf_rr_pick
    import tcp_pkg::*;
#(
    parameter int NUM_CP   = RX_STORE_BUF_NUM_CP,
    parameter int CP_IDX_W = cp_idx_w(NUM_CP)
) (
    input  logic [NUM_CP-1:0]   eligible,
    input  logic [CP_IDX_W-1:0] rr_ptr,
    output logic [CP_IDX_W-1:0] grant_idx,
    output logic                any_grant
);

    logic [CP_IDX_W-1:0] idx;

    always_comb begin
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_CP; k++) begin
            idx = CP_IDX_W'((int'(rr_ptr) + k) % NUM_CP);
            if (!any_grant && eligible[idx]) begin
                grant_idx = idx;
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_store_buf_dispatch.sv
// Pops the shared RX store-buffer queue and offers each entry to one free copier, round-robin, flow-ordered.
// Latency: head popped at t, offered at t+2; back-to-back one dispatch per 2 cycles.
// Backpressure: holds the entry in OFFER until the target copier pops; no queue pop meanwhile.
module rx_store_buf_dispatch
    import tcp_pkg::*;
#(
    parameter int NUM_CP   = RX_STORE_BUF_NUM_CP,
    parameter int CP_IDX_W = cp_idx_w(NUM_CP),
    parameter int CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 read_store_buf_q_req_val,
    input  rx_store_buf_q_struct read_store_buf_q_req_data,
    input  logic                 read_store_buf_q_empty,
    input  logic [NUM_CP-1:0]    cp_q_req_val,
    output rx_store_buf_q_struct cp_q_req_data,
    output logic [NUM_CP-1:0]    cp_q_empty,
    input  logic [NUM_CP-1:0]    cp_done,
    output logic [CNT_W-1:0]     dispatch_cnt,
    output logic [CNT_W-1:0]     flow_stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_OFFER
    } state_t;

    state_t               state;
    rx_store_buf_q_struct ent;
    logic [NUM_CP-1:0]    busy;
    logic [FLOWID_W-1:0]  cp_flowid [NUM_CP];
    logic [CP_IDX_W-1:0]  tgt;
    logic [CP_IDX_W-1:0]  rr_ptr;
    logic [CP_IDX_W-1:0]  rr_next;

    logic                 conflict;
    logic [NUM_CP-1:0]    eligible;
    logic [CP_IDX_W-1:0]  grant_idx;
    logic                 any_grant;
    logic [NUM_CP-1:0]    grant_oh;
    logic                 handshake;
    logic                 pop;

    // A flow already being committed by any copier blocks every copier.
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < NUM_CP; i++) begin
            if (busy[i] && (cp_flowid[i] == ent.flowid)) begin
                conflict = 1'b1;
            end
        end
    end

    assign eligible = conflict ? '0 : ~busy;

    rx_store_buf_rr_pick #(
        .NUM_CP   (NUM_CP),
        .CP_IDX_W (CP_IDX_W)
    ) u_rr_pick (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        grant_oh            = '0;
        grant_oh[grant_idx] = 1'b1;
    end

    assign rr_next   = (tgt == CP_IDX_W'(NUM_CP - 1)) ? '0 : tgt + 1'b1;
    assign handshake = (state == ST_OFFER) && cp_q_req_val[tgt];
    assign pop       = rst_n && !read_store_buf_q_empty && ((state == ST_IDLE) || handshake);

    assign read_store_buf_q_req_val = pop;
    assign cp_q_req_data            = ent;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            ent            <= '0;
            busy           <= '0;
            tgt            <= '0;
            rr_ptr         <= '0;
            cp_q_empty     <= '1;
            dispatch_cnt   <= '0;
            flow_stall_cnt <= '0;
            for (int i = 0; i < NUM_CP; i++) begin
                cp_flowid[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CP; i++) begin
                if (cp_done[i]) begin
                    busy[i] <= 1'b0;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        ent   <= read_store_buf_q_req_data;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (conflict && !(&busy)) begin
                        flow_stall_cnt <= flow_stall_cnt + 1'b1;
                    end
                    if (any_grant) begin
                        tgt        <= grant_idx;
                        cp_q_empty <= ~grant_oh;
                        state      <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (handshake) begin
                        busy[tgt]      <= 1'b1;
                        cp_flowid[tgt] <= ent.flowid;
                        rr_ptr         <= rr_next;
                        dispatch_cnt   <= dispatch_cnt + 1'b1;
                        cp_q_empty     <= '1;
                        if (pop) begin
                            ent   <= read_store_buf_q_req_data;
                            state <= ST_WAIT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // cp_q_empty is all-ones outside OFFER, so this also covers pops in other states.
    a_pop_only_offered: assert property (@(posedge clk) disable iff (!rst_n)
        (cp_q_req_val & cp_q_empty) == '0);
    a_done_only_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (cp_done & ~busy) == '0);

endmodule
